// File: rtl/cs_pkg.sv
// rtl/cs_pkg.sv - shared types and constants for the vector fetch unit
//   fetch_state_e : fetch FSM states
//   ELEM_BYTES    : byte stride between consecutive vector elements
//   pair_t        : operand pair register {a, b, last}
package cs_pkg;

   localparam int ELEM_BYTES  = 4;
   localparam int PAIR_DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_A,
      ST_RSP_A,
      ST_REQ_B,
      ST_RSP_B,
      ST_PUSH,
      ST_DONE
   } fetch_state_e;

   typedef struct packed {
      logic [PAIR_DATA_W-1:0] a;
      logic [PAIR_DATA_W-1:0] b;
      logic                   last;
   } pair_t;

endpackage

// File: rtl/vfu_obi_rd.sv
// rtl/vfu_obi_rd.sv - single-outstanding OBI read handshaker
//   clk_i, rst_i     : clock, async active-high reset
//   rd_req_i         : client wants a read issued (held until rd_gnt_o)
//   rd_addr_i        : byte address for that read
//   rd_gnt_o         : request accepted by the bus this cycle
//   rsp_valid_o      : response for the outstanding read is present
//   rsp_data_o       : response data
//   rsp_err_o        : response flagged as error
//   obi_*            : OBI read port (req/addr out, gnt/rvalid/rdata/err in)
module vfu_obi_rd #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              rd_gnt_o,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              obi_req_o,
   output logic [ADDR_W-1:0] obi_addr_o,
   input  logic              obi_gnt_i,
   input  logic              obi_rvalid_i,
   input  logic [DATA_W-1:0] obi_rdata_i,
   input  logic              obi_err_i
);

   logic pend_q, pend_d;

   // A new request is never raised while one is still awaiting its response.
   assign obi_req_o   = rd_req_i & ~pend_q;
   assign obi_addr_o  = obi_req_o ? rd_addr_i : '0;
   assign rd_gnt_o    = obi_req_o & obi_gnt_i;
   // rvalid without an outstanding request is a stray and is dropped here.
   assign rsp_valid_o = pend_q & obi_rvalid_i;
   assign rsp_data_o  = obi_rdata_i;
   assign rsp_err_o   = pend_q & obi_rvalid_i & obi_err_i;

   always_comb begin
      pend_d = pend_q;
      if (rd_gnt_o) begin
         pend_d = 1'b1;
      end else if (rsp_valid_o) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/vec_fetch_unit.sv
// rtl/vec_fetch_unit.sv - fetches A[k]/B[k] over OBI and streams operand pairs
//   start_i, base_a_i, base_b_i, len_i : job launch (sampled in IDLE only)
//   busy_o, done_o                     : job status, done_o is a 1-cycle pulse
//   obi_req_o/addr_o/gnt_i/rvalid_i/rdata_i : OBI read port
//   pair_valid_o/pair_ready_i, op_a_o, op_b_o, last_o : operand pair stream
//   Optional macro VFU_ERR_EN adds obi_err_i and sticky err_o.
module vec_fetch_unit
   import cs_pkg::*;
#(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_a_i,
   input  logic [ADDR_W-1:0] base_b_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              obi_req_o,
   output logic [ADDR_W-1:0] obi_addr_o,
   input  logic              obi_gnt_i,
   input  logic              obi_rvalid_i,
   input  logic [DATA_W-1:0] obi_rdata_i,
`ifdef VFU_ERR_EN
   input  logic              obi_err_i,
   output logic              err_o,
`endif
   output logic              pair_valid_o,
   input  logic              pair_ready_i,
   output logic [DATA_W-1:0] op_a_o,
   output logic [DATA_W-1:0] op_b_o,
   output logic              last_o
);

   fetch_state_e      state_q, state_d;
   logic [LEN_W-1:0]  k_q, k_d, len_q, len_d;
   logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d;
   logic [DATA_W-1:0] a_hold_q, a_hold_d;
   pair_t             pair_q, pair_d;

   logic              rd_req, rd_gnt, rsp_valid, rsp_err, bus_err;
   logic [ADDR_W-1:0] rd_addr, elem_off;
   logic [DATA_W-1:0] rsp_data;

`ifdef VFU_ERR_EN
   logic err_q, err_d;
   assign bus_err = obi_err_i;
   assign err_o   = err_q;
`else
   assign bus_err = 1'b0;
`endif

   assign elem_off = ADDR_W'(k_q) * ADDR_W'(ELEM_BYTES);
   assign rd_addr  = ((state_q == ST_REQ_B) ? base_b_q : base_a_q) + elem_off;

   vfu_obi_rd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_obi_rd (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rd_req_i     (rd_req),
      .rd_addr_i    (rd_addr),
      .rd_gnt_o     (rd_gnt),
      .rsp_valid_o  (rsp_valid),
      .rsp_data_o   (rsp_data),
      .rsp_err_o    (rsp_err),
      .obi_req_o    (obi_req_o),
      .obi_addr_o   (obi_addr_o),
      .obi_gnt_i    (obi_gnt_i),
      .obi_rvalid_i (obi_rvalid_i),
      .obi_rdata_i  (obi_rdata_i),
      .obi_err_i    (bus_err)
   );

   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = (state_q == ST_DONE);
   assign pair_valid_o = (state_q == ST_PUSH);
   assign op_a_o       = pair_q.a;
   assign op_b_o       = pair_q.b;
   assign last_o       = pair_q.last;

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      len_d    = len_q;
      base_a_d = base_a_q;
      base_b_d = base_b_q;
      a_hold_d = a_hold_q;
      pair_d   = pair_q;
      rd_req   = 1'b0;
`ifdef VFU_ERR_EN
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               base_a_d = base_a_i;
               base_b_d = base_b_i;
               len_d    = len_i;
               k_d      = '0;
`ifdef VFU_ERR_EN
               err_d    = 1'b0;
`endif
               state_d  = (len_i == '0) ? ST_DONE : ST_REQ_A;
            end
         end
         ST_REQ_A: begin
            rd_req = 1'b1;
            if (rd_gnt) state_d = ST_RSP_A;
         end
         ST_RSP_A: begin
            if (rsp_valid) begin
               if (rsp_err) begin
`ifdef VFU_ERR_EN
                  err_d = 1'b1;
`endif
                  state_d = ST_DONE;
               end else begin
                  a_hold_d = rsp_data;
                  state_d  = ST_REQ_B;
               end
            end
         end
         ST_REQ_B: begin
            rd_req = 1'b1;
            if (rd_gnt) state_d = ST_RSP_B;
         end
         ST_RSP_B: begin
            if (rsp_valid) begin
               if (rsp_err) begin
`ifdef VFU_ERR_EN
                  err_d = 1'b1;
`endif
                  state_d = ST_DONE;
               end else begin
                  pair_d.a    = a_hold_q;
                  pair_d.b    = rsp_data;
                  pair_d.last = (k_q == len_q - LEN_W'(1));
                  state_d     = ST_PUSH;
               end
            end
         end
         ST_PUSH: begin
            if (pair_ready_i) begin
               k_d     = k_q + LEN_W'(1);
               state_d = pair_q.last ? ST_DONE : ST_REQ_A;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         k_q      <= '0;
         len_q    <= '0;
         base_a_q <= '0;
         base_b_q <= '0;
         a_hold_q <= '0;
         pair_q   <= '0;
`ifdef VFU_ERR_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         len_q    <= len_d;
         base_a_q <= base_a_d;
         base_b_q <= base_b_d;
         a_hold_q <= a_hold_d;
         pair_q   <= pair_d;
`ifdef VFU_ERR_EN
         err_q    <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_vec_fetch_unit.sv
// tb/tb_vec_fetch_unit.sv - self-checking bench for vec_fetch_unit
module tb_vec_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] base_a_i, base_b_i;
   logic [15:0] len_i;
   logic        busy_o, done_o;
   logic        obi_req_o;
   logic [31:0] obi_addr_o;
   logic        obi_gnt_i, obi_rvalid_i;
   logic [31:0] obi_rdata_i;
   logic        pair_valid_o, pair_ready_i;
   logic [31:0] op_a_o, op_b_o;
   logic        last_o;
`ifdef VFU_ERR_EN
   logic        obi_err_i, err_o;
`endif

   vec_fetch_unit dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .base_a_i     (base_a_i),
      .base_b_i     (base_b_i),
      .len_i        (len_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .obi_req_o    (obi_req_o),
      .obi_addr_o   (obi_addr_o),
      .obi_gnt_i    (obi_gnt_i),
      .obi_rvalid_i (obi_rvalid_i),
      .obi_rdata_i  (obi_rdata_i),
`ifdef VFU_ERR_EN
      .obi_err_i    (obi_err_i),
      .err_o        (err_o),
`endif
      .pair_valid_o (pair_valid_o),
      .pair_ready_i (pair_ready_i),
      .op_a_o       (op_a_o),
      .op_b_o       (op_b_o),
      .last_o       (last_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        last;
   } pair_s;

   typedef struct {
      logic [31:0] ba;
      logic [31:0] bb;
      int          len;
      int          gmax;
      int          rvmax;
      int          rdy;
      bit          stray;
      int          exp_lat;
   } vec_t;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %0h exp %0h", nm, got, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // bus / consumer configuration and observation
   int          gnt_max = 0, rv_max = 1, ready_pct = 100, hold_left = 0;
   bit          stray_en = 0;
   logic [31:0] stall_addr = 32'h1;
   int          stall_len = 0, stall_cnt = 0, done_cnt = 0;
   bit          err_inject = 0;
   logic [31:0] err_addr = 32'h1;
   logic [31:0] got_addr[$];
   pair_s       got_pairs[$];

   // slave/consumer internal state
   bit          pend = 0, req_seen = 0, prev_req_stall = 0, prev_pv_stall = 0;
   int          pend_cnt = 0, gnt_wait = 0;
   logic [31:0] pend_addr = '0, prev_addr = '0;
   logic [63:0] prev_ab = '0;
   logic        prev_last = 1'b0;

   initial begin
      obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = '0; pair_ready_i = 0;
`ifdef VFU_ERR_EN
      obi_err_i = 0;
`endif
   end

   // Memory slave, FPU consumer and stability monitor; all act on the falling edge.
   always @(negedge clk_i) begin
      if (rst_i) begin
         pend = 0; req_seen = 0; prev_req_stall = 0; prev_pv_stall = 0;
         obi_gnt_i = 0; obi_rvalid_i = 0; pair_ready_i = 0;
`ifdef VFU_ERR_EN
         obi_err_i = 0;
`endif
      end else begin
         if (prev_req_stall) begin
            check("req_hold", {31'd0, obi_req_o}, 64'd1);
            check("addr_hold", {32'd0, obi_addr_o}, {32'd0, prev_addr});
         end
         if (prev_pv_stall) begin
            check("pair_hold", {op_a_o, op_b_o}, prev_ab);
            check("pv_last_hold", {62'd0, pair_valid_o, last_o}, {62'd0, 1'b1, prev_last});
         end
         if (pair_valid_o) check("no_req_in_push", {63'd0, obi_req_o}, 64'd0);
         if (done_o) done_cnt++;
         // response channel
         obi_rvalid_i = 0;
         obi_rdata_i  = $urandom;
`ifdef VFU_ERR_EN
         obi_err_i    = 0;
`endif
         if (pend) begin
            if (pend_cnt == 0) begin
               obi_rvalid_i = 1;
               obi_rdata_i  = mem_word(pend_addr);
`ifdef VFU_ERR_EN
               obi_err_i    = err_inject && (pend_addr == err_addr);
`endif
               pend = 0;
            end else begin
               pend_cnt--;
            end
         end else if (stray_en && $urandom_range(0, 3) == 0) begin
            obi_rvalid_i = 1;
         end
         // request channel
         obi_gnt_i = 0;
         if (obi_req_o) begin
            if (obi_addr_o == stall_addr) stall_cnt++;
            if (!req_seen) begin
               req_seen = 1;
               gnt_wait = (obi_addr_o == stall_addr) ? stall_len : $urandom_range(0, gnt_max);
            end
            if (gnt_wait == 0) begin
               obi_gnt_i = 1;
               req_seen  = 0;
               pend      = 1;
               pend_cnt  = $urandom_range(1, rv_max) - 1;
               pend_addr = obi_addr_o;
               got_addr.push_back(obi_addr_o);
            end else begin
               gnt_wait--;
            end
         end else begin
            req_seen = 0;
         end
         prev_req_stall = obi_req_o && !obi_gnt_i;
         prev_addr      = obi_addr_o;
         // consumer
         if (pair_valid_o) begin
            if (hold_left > 0) begin
               pair_ready_i = 0;
               hold_left--;
            end else begin
               pair_ready_i = ($urandom_range(0, 99) < ready_pct);
            end
            if (pair_ready_i) got_pairs.push_back('{op_a_o, op_b_o, last_o});
         end else begin
            pair_ready_i = $urandom_range(0, 1);
         end
         prev_pv_stall = pair_valid_o && !pair_ready_i;
         prev_ab       = {op_a_o, op_b_o};
         prev_last     = last_o;
      end
   end

   // Launches one job, checks latency, request order and the pair stream
   // against a list built from the vector contents.
   task automatic run_job(input vec_t v, input int err_k, input int hold);
      logic [31:0] ea[$];
      pair_s       ep[$];
      int          n_a, n_p, cyc, lat;
      n_a = (err_k >= 0) ? err_k + 1 : v.len;
      n_p = (err_k >= 0) ? err_k : v.len;
      for (int k = 0; k < n_a; k++) begin
         ea.push_back(v.ba + 32'(4 * k));
         if (k != err_k) ea.push_back(v.bb + 32'(4 * k));
      end
      for (int k = 0; k < n_p; k++)
         ep.push_back('{mem_word(v.ba + 32'(4 * k)), mem_word(v.bb + 32'(4 * k)), (k == v.len - 1)});
      gnt_max = v.gmax; rv_max = v.rvmax; ready_pct = v.rdy; stray_en = v.stray; hold_left = hold;
      err_inject = (err_k >= 0);
      err_addr   = v.ba + 32'(4 * err_k);
      got_addr.delete(); got_pairs.delete(); done_cnt = 0; stall_cnt = 0;
      start_i = 1; base_a_i = v.ba; base_b_i = v.bb; len_i = 16'(v.len);
      cyc = 0; lat = -1;
      while (lat < 0 && cyc < 3000) begin
         @(negedge clk_i); #2;
         cyc++;
         if (done_cnt > 0) lat = cyc;
         if (cyc == 1) start_i = 0;
         if (cyc == 2 && busy_o) begin
            start_i = 1; base_a_i = $urandom; base_b_i = $urandom;
            len_i = 16'($urandom_range(0, 9));
         end
         if (cyc == 3) start_i = 0;
      end
      start_i = 0;
      check("done_seen", {63'd0, lat >= 0}, 64'd1);
      if (v.exp_lat > 0) check("latency", 64'(lat), 64'(v.exp_lat));
      @(negedge clk_i); #2;
      check("done_pulse_idle", {61'd0, done_o, busy_o, done_cnt == 1}, 64'd1);
      check("n_req", 64'(got_addr.size()), 64'(ea.size()));
      foreach (ea[i]) if (i < got_addr.size()) check("req_addr", {32'd0, got_addr[i]}, {32'd0, ea[i]});
      check("n_pair", 64'(got_pairs.size()), 64'(ep.size()));
      foreach (ep[i]) if (i < got_pairs.size()) begin
         check("pair_ab", {got_pairs[i].a, got_pairs[i].b}, {ep[i].a, ep[i].b});
         check("pair_last", {63'd0, got_pairs[i].last}, {63'd0, ep[i].last});
      end
      hold_left = 0; err_inject = 0;
   endtask

   vec_t vecs[6];
   vec_t rv;
   int   wait_cyc;

   initial begin
      rst_i = 1; start_i = 0; base_a_i = '0; base_b_i = '0; len_i = '0;
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_ctl", {59'd0, busy_o, done_o, obi_req_o, pair_valid_o, last_o}, 64'd0);
      check("rst_addr", {32'd0, obi_addr_o}, 64'd0);
      check("rst_ops", {op_a_o, op_b_o}, 64'd0);
      #1 rst_i = 0;

      vecs[0] = '{32'h1000, 32'h2000, 3, 0, 1, 100, 0, 16};
      vecs[1] = '{32'h3000, 32'h4000, 0, 0, 1, 100, 0, 1};
      vecs[2] = '{32'hFFFF_FFF8, 32'h10, 4, 0, 1, 100, 0, 21};
      vecs[3] = '{32'h4000, 32'h8000, 1, 0, 1, 100, 0, 6};
      vecs[4] = '{32'h100, 32'h200, 7, 3, 3, 60, 1, -1};
      vecs[5] = '{32'h1234_0000, 32'h0, 5, 2, 4, 50, 1, -1};
      for (int i = 0; i < 6; i++) run_job(vecs[i], -1, 0);

      // grant withheld three cycles on B[0]
      stall_addr = 32'h2000; stall_len = 3;
      run_job('{32'h1000, 32'h2000, 2, 0, 1, 100, 0, 14}, -1, 0);
      check("stall_req_cycles", 64'(stall_cnt), 64'd4);
      stall_addr = 32'h1;

      // consumer refuses the first pair for five cycles
      run_job('{32'h1000, 32'h2000, 2, 0, 1, 100, 0, 16}, -1, 5);

      // reset while waiting on the B[0] response
      gnt_max = 0; rv_max = 3; stray_en = 0; ready_pct = 100;
      got_addr.delete();
      start_i = 1; base_a_i = 32'h5000; base_b_i = 32'h6000; len_i = 16'd3;
      @(negedge clk_i); #2;
      start_i = 0;
      wait_cyc = 0;
      while (got_addr.size() < 2 && wait_cyc < 200) begin
         @(negedge clk_i); #2;
         wait_cyc++;
      end
      check("reach_req_b", 64'(got_addr.size()), 64'd2);
      @(negedge clk_i); #2;
      rst_i = 1;
      #1;
      check("midrst_ctl", {59'd0, busy_o, done_o, obi_req_o, pair_valid_o, last_o}, 64'd0);
      check("midrst_addr", {32'd0, obi_addr_o}, 64'd0);
      check("midrst_ops", {op_a_o, op_b_o}, 64'd0);
      repeat (2) @(negedge clk_i);
      #2 rst_i = 0;
      run_job(vecs[0], -1, 0);

`ifdef VFU_ERR_EN
      run_job('{32'h7000, 32'h9000, 4, 0, 1, 100, 0, -1}, 1, 0);
      check("err_sticky", {63'd0, err_o}, 64'd1);
      repeat (3) @(negedge clk_i);
      #2 check("err_still", {63'd0, err_o}, 64'd1);
      run_job(vecs[3], -1, 0);
      check("err_cleared", {63'd0, err_o}, 64'd0);
`endif

      for (int j = 0; j < 8; j++) begin
         rv.ba    = $urandom & 32'hFFFF_FFFC;
         rv.bb    = $urandom & 32'hFFFF_FFFC;
         rv.len   = $urandom_range(1, 6);
         rv.gmax  = $urandom_range(0, 3);
         rv.rvmax = $urandom_range(1, 4);
         rv.rdy   = $urandom_range(30, 100);
         rv.stray = 1;
         rv.exp_lat = -1;
         run_job(rv, -1, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

endmodule
